// File: rtl/collatz_host_driver.sv
// collatz_host_driver
//   Host-side initiator for the byte-addressed collatz compute peripheral.
//   It takes a seed on a valid/ready command port, resets the peripheral,
//   writes the seed one byte at a time, pulses go, and waits for the
//   peripheral to enter and then leave COMPUTE mode. It then reads back the
//   orbit length and the high 16 bits of the path record, and reports them
//   on a one-cycle response.
//
// Ports
//   clk, reset         clock shared with the peripheral; synchronous active-high reset
//   cmd_valid/ready    command handshake; ready is high only in IDLE
//   cmd_seed           seed, captured on the handshake
//   rsp_valid          one-cycle pulse; the rsp_* fields hold until the next response
//   rsp_orbit_len      orbit length read from the peripheral
//   rsp_path_h16       high 16 bits of the path record
//   rsp_error          0 ok, 1 zero seed rejected, 2 compute timeout
//   dev_rst_n          peripheral reset (active low)
//   dev_ui_in          write data byte
//   dev_uio_in         [7]=write_en [6]=go [5]=path_sel [4:0]=addr
//   dev_uo_out         read data (registered inside the peripheral)
//   dev_uio_out        [7]=busy (not needed: the oe[7] transitions are enough)
//   dev_uio_oe         8'h80 while in COMPUTE, 8'h00 in IO mode
module collatz_host_driver #(
  parameter int SEED_BITS = 144,
  parameter int MAX_WAIT  = 2**20,
  parameter int RST_CYC   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [SEED_BITS-1:0] cmd_seed,
  output logic                 rsp_valid,
  output logic [15:0]          rsp_orbit_len,
  output logic [15:0]          rsp_path_h16,
  output logic [1:0]           rsp_error,
  output logic                 dev_rst_n,
  output logic [7:0]           dev_ui_in,
  output logic [7:0]           dev_uio_in,
  input  logic [7:0]           dev_uo_out,
  input  logic [7:0]           dev_uio_out,
  input  logic [7:0]           dev_uio_oe
);

  localparam int NBYTES = SEED_BITS / 8;
  localparam int BW     = $clog2(NBYTES);
  localparam int CWR    = $clog2(MAX_WAIT + 1);
  localparam int CW     = (CWR > 5) ? CWR : 5;

  typedef enum logic [3:0] {
    S_IDLE, S_REJ, S_DRST, S_WRITE, S_START,
    S_WENTER, S_WEXIT, S_READ, S_DONE, S_TRST, S_TRSP
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [SEED_BITS-1:0]    r_seed;
  logic                    w_seed_ld;
  logic [NBYTES-1:0][7:0]  w_seed_bytes;
  logic [3:0][7:0]         r_cap, w_cap_nxt;
  logic [1:0]              w_cap_idx;
  logic                    w_timeout;

  logic                    r_rsp_valid, w_rsp_valid_nxt;
  logic [15:0]             r_rsp_orbit, w_rsp_orbit_nxt;
  logic [15:0]             r_rsp_path,  w_rsp_path_nxt;
  logic [1:0]              r_rsp_error, w_rsp_error_nxt;
  logic                    r_dev_rst_n, w_dev_rst_n_nxt;
  logic [7:0]              r_dev_ui,    w_dev_ui_nxt;
  logic [7:0]              r_dev_uio,   w_dev_uio_nxt;

  // Busy is redundant with the oe[7] edges, and the low oe bits carry nothing.
  logic w_unused;
  assign w_unused = ^{dev_uio_out, dev_uio_oe[6:0]};

  assign w_cnt_inc    = r_cnt + 1'b1;
  // One shared counter covers both wait states, so a single compare is enough.
  assign w_timeout    = (w_cnt_inc >= CW'(MAX_WAIT));
  assign w_seed_bytes = r_seed;
  // The READ capture for cycle c lands in byte c-1; cycle 4 wraps to index 3.
  assign w_cap_idx    = r_cnt[1:0] - 2'd1;

  // Next state and counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_seed_ld   = 1'b0;
    w_cap_nxt   = r_cap;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_seed == '0) begin
            w_state_nxt = S_REJ;
          end else begin
            w_state_nxt = S_DRST;
            w_seed_ld   = 1'b1;
            w_cnt_nxt   = '0;
          end
        end
      end
      S_REJ, S_DONE, S_TRSP: w_state_nxt = S_IDLE;
      S_DRST, S_TRST: begin
        if (r_cnt == CW'(RST_CYC - 1)) begin
          w_state_nxt = (r_state == S_DRST) ? S_WRITE : S_TRSP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_WRITE: begin
        if (r_cnt == CW'(NBYTES - 1)) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_START: begin
        w_state_nxt = S_WENTER;
        w_cnt_nxt   = '0;
      end
      // Sample oe[7] every cycle: a 1-cycle COMPUTE excursion must not be missed.
      S_WENTER: begin
        if (dev_uio_oe[7]) begin
          w_state_nxt = S_WEXIT;
          w_cnt_nxt   = w_cnt_inc;
        end else if (w_timeout) begin
          w_state_nxt = S_TRST;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_WEXIT: begin
        if (!dev_uio_oe[7]) begin
          w_state_nxt = S_READ;
          w_cnt_nxt   = '0;
        end else if (w_timeout) begin
          w_state_nxt = S_TRST;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      // Cycles 0..3 issue addresses; cycles 1..4 capture the data registered
      // by the peripheral for the address issued one cycle earlier.
      S_READ: begin
        if (r_cnt != '0) w_cap_nxt[w_cap_idx] = dev_uo_out;
        if (r_cnt == CW'(4)) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state, so pins line up
  // with the state register.
  always_comb begin
    w_dev_rst_n_nxt = r_dev_rst_n;
    w_dev_ui_nxt    = 8'h00;
    w_dev_uio_nxt   = 8'h00;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_error_nxt = r_rsp_error;
    w_rsp_orbit_nxt = r_rsp_orbit;
    w_rsp_path_nxt  = r_rsp_path;
    case (w_state_nxt)
      S_DRST, S_TRST: w_dev_rst_n_nxt = 1'b0;
      S_WRITE: begin
        w_dev_rst_n_nxt = 1'b1;
        w_dev_ui_nxt    = w_seed_bytes[w_cnt_nxt[BW-1:0]];
        w_dev_uio_nxt   = {1'b1, 2'b00, w_cnt_nxt[4:0]};
      end
      S_START: begin
        w_dev_rst_n_nxt = 1'b1;
        w_dev_uio_nxt   = 8'h40;
      end
      S_WENTER, S_WEXIT: w_dev_rst_n_nxt = 1'b1;
      S_READ: begin
        w_dev_rst_n_nxt = 1'b1;
        // Cycle 4 issues 0/0 again, which is harmless and keeps this a pure decode.
        w_dev_uio_nxt   = {2'b00, w_cnt_nxt[1], 4'b0000, w_cnt_nxt[0]};
      end
      S_DONE: begin
        w_dev_rst_n_nxt = 1'b1;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_error_nxt = 2'd0;
        w_rsp_orbit_nxt = {w_cap_nxt[1], w_cap_nxt[0]};
        w_rsp_path_nxt  = {w_cap_nxt[3], w_cap_nxt[2]};
      end
      S_REJ: begin
        w_rsp_valid_nxt = 1'b1;
        w_rsp_error_nxt = 2'd1;
        w_rsp_orbit_nxt = 16'h0;
        w_rsp_path_nxt  = 16'h0;
      end
      S_TRSP: begin
        w_dev_rst_n_nxt = 1'b1;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_error_nxt = 2'd2;
        w_rsp_orbit_nxt = 16'h0;
        w_rsp_path_nxt  = 16'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_seed      <= '0;
      r_cap       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_orbit <= 16'h0;
      r_rsp_path  <= 16'h0;
      r_rsp_error <= 2'd0;
      r_dev_rst_n <= 1'b0;
      r_dev_ui    <= 8'h00;
      r_dev_uio   <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cap       <= w_cap_nxt;
      if (w_seed_ld) r_seed <= cmd_seed;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_orbit <= w_rsp_orbit_nxt;
      r_rsp_path  <= w_rsp_path_nxt;
      r_rsp_error <= w_rsp_error_nxt;
      r_dev_rst_n <= w_dev_rst_n_nxt;
      r_dev_ui    <= w_dev_ui_nxt;
      r_dev_uio   <= w_dev_uio_nxt;
    end
  end

  assign cmd_ready     = (r_state == S_IDLE);
  assign rsp_valid     = r_rsp_valid;
  assign rsp_orbit_len = r_rsp_orbit;
  assign rsp_path_h16  = r_rsp_path;
  assign rsp_error     = r_rsp_error;
  assign dev_rst_n     = r_dev_rst_n;
  assign dev_ui_in     = r_dev_ui;
  assign dev_uio_in    = r_dev_uio;

endmodule

// File: tb/tb_collatz_host_driver.sv
// Bench for collatz_host_driver. It has two driver instances, each with its
// own behavioural peripheral model: [0] uses the default MAX_WAIT and [1] uses
// MAX_WAIT=16. Each model does one collatz step per COMPUTE cycle and keeps
// adding to its orbit count until dev_rst_n clears it.
module tb_collatz_host_driver;
  localparam int SB = 144;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          cmd_valid [2];
  logic [SB-1:0] cmd_seed [2];
  logic          cmd_ready [2];
  logic          rsp_valid [2];
  logic [15:0]   rsp_orbit_len [2];
  logic [15:0]   rsp_path_h16 [2];
  logic [1:0]    rsp_error [2];
  logic          dev_rst_n [2];
  logic [7:0]    dev_ui_in [2], dev_uio_in [2], dev_uo_out [2], dev_uio_out [2], dev_uio_oe [2];

  for (genvar g = 0; g < 2; g++) begin : gi
    collatz_host_driver #(.SEED_BITS(SB), .MAX_WAIT(g == 0 ? 1048576 : 16), .RST_CYC(2)) u_dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_seed(cmd_seed[g]),
      .rsp_valid(rsp_valid[g]), .rsp_orbit_len(rsp_orbit_len[g]),
      .rsp_path_h16(rsp_path_h16[g]), .rsp_error(rsp_error[g]),
      .dev_rst_n(dev_rst_n[g]), .dev_ui_in(dev_ui_in[g]), .dev_uio_in(dev_uio_in[g]),
      .dev_uo_out(dev_uo_out[g]), .dev_uio_out(dev_uio_out[g]), .dev_uio_oe(dev_uio_oe[g]));
  end

  // ---------------- peripheral model ----------------
  logic [SB-1:0] m_seed [2], m_val [2], m_max [2], m_nv [2];
  logic [15:0]   m_orbit [2];
  logic          m_comp [2];
  logic [7:0]    m_uo [2];
  int            m_wa [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      m_nv[i]        = m_val[i][0] ? ((m_val[i] << 1) + m_val[i] + 1'b1) : (m_val[i] >> 1);
      m_wa[i]        = 8 * int'(dev_uio_in[i][4:0]);
      dev_uo_out[i]  = m_uo[i];
      dev_uio_oe[i]  = m_comp[i] ? 8'h80 : 8'h00;
      dev_uio_out[i] = {m_comp[i], 7'd0};
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!dev_rst_n[i]) begin
        m_seed[i] <= '0; m_val[i] <= '0; m_max[i] <= '0;
        m_orbit[i] <= '0; m_comp[i] <= 1'b0; m_uo[i] <= '0;
      end else if (m_comp[i]) begin
        m_val[i]   <= m_nv[i];
        m_orbit[i] <= m_orbit[i] + 16'd1;
        if (m_nv[i] > m_max[i]) m_max[i] <= m_nv[i];
        if (m_nv[i] == SB'(1)) m_comp[i] <= 1'b0;
      end else begin
        if (dev_uio_in[i][7]) m_seed[i][m_wa[i] +: 8] <= dev_ui_in[i];
        else if (dev_uio_in[i][6] && (m_seed[i] >> 1) != '0) begin
          m_comp[i] <= 1'b1; m_val[i] <= m_seed[i]; m_max[i] <= m_seed[i];
        end
        case ({dev_uio_in[i][5], dev_uio_in[i][0]})
          2'b00:   m_uo[i] <= m_orbit[i][7:0];
          2'b01:   m_uo[i] <= m_orbit[i][15:8];
          2'b10:   m_uo[i] <= m_max[i][135:128];
          default: m_uo[i] <= m_max[i][143:136];
        endcase
      end
    end
  end

  // ---------------- pin monitors (cumulative) ----------------
  int wr_cnt [2], run [2], addr_err [2], act_cnt [2], rstlow [2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (dev_uio_in[i][7]) begin
        wr_cnt[i] <= wr_cnt[i] + 1;
        run[i]    <= run[i] + 1;
        if (int'(dev_uio_in[i][4:0]) != run[i]) addr_err[i] <= addr_err[i] + 1;
      end else begin
        run[i] <= 0;
      end
      if (!dev_rst_n[i]) rstlow[i] <= rstlow[i] + 1;
      if (!dev_rst_n[i] || dev_ui_in[i] != 8'h00 || dev_uio_in[i] != 8'h00) act_cnt[i] <= act_cnt[i] + 1;
    end
  end

  // ---------------- checking ----------------
  int checks = 0, errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one command and wait (bounded) for its response. lat is counted in
  // cycles from the handshake edge; the d* outputs are monitor deltas over
  // cycles 1..lat.
  task automatic run_cmd(input int i, input logic [SB-1:0] seed, output logic got, output int lat,
                         output logic [15:0] orb, output logic [15:0] pth, output logic [1:0] err,
                         output int dwr, output int drst, output int dact, output int daerr);
    int n, s_wr, s_rst, s_act, s_ae;
    got = 0; lat = 0; orb = 0; pth = 0; err = 0; dwr = 0; drst = 0; dact = 0; daerr = 0;
    n = 0;
    @(negedge clk);
    while (!cmd_ready[i] && n < 50) begin @(negedge clk); n++; end
    cmd_valid[i] = 1'b1; cmd_seed[i] = seed;
    @(posedge clk); #1;
    cmd_valid[i] = 1'b0; cmd_seed[i] = ~seed;
    s_wr = wr_cnt[i]; s_rst = rstlow[i]; s_act = act_cnt[i]; s_ae = addr_err[i];
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (rsp_valid[i]) begin
        got = 1; lat = c; orb = rsp_orbit_len[i]; pth = rsp_path_h16[i]; err = rsp_error[i];
        break;
      end
    end
    if (got) begin
      @(posedge clk); #1;
      dwr = wr_cnt[i] - s_wr; drst = rstlow[i] - s_rst;
      dact = act_cnt[i] - s_act; daerr = addr_err[i] - s_ae;
      @(negedge clk);
      chk("rsp_pulse_one_cycle", rsp_valid[i], 0);
      chk("rsp_orbit_hold", rsp_orbit_len[i], orb);
    end
  endtask

  typedef struct {
    int          inst;
    logic [SB-1:0] seed;
    logic [15:0] orbit;
    logic [15:0] path;
    logic [1:0]  err;
    int          lat;
    int          wr;
    int          rl;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic got; int lat, dwr, drst, dact, dae, hits;
    logic [15:0] orb, pth; logic [1:0] err;

    // ok latency = 2 rst + 18 writes + 1 start + (steps+1) wait + 5 read + 1 = 28 + steps
    vt[0] = '{0, SB'(27),          16'd111, 16'h0000, 2'd0, 139, 18, 2};
    vt[1] = '{0, SB'(6),           16'd8,   16'h0000, 2'd0, 36,  18, 2};
    vt[2] = '{0, SB'(6),           16'd8,   16'h0000, 2'd0, 36,  18, 2};
    vt[3] = '{0, SB'(1) << 140,    16'd140, 16'h1000, 2'd0, 168, 18, 2};
    vt[4] = '{0, SB'(2),           16'd1,   16'h0000, 2'd0, 29,  18, 2};
    vt[5] = '{0, SB'(0),           16'd0,   16'h0000, 2'd1, 1,   0,  0};
    // timeout: 16 wait cycles, then 2 more reset cycles, then the response
    vt[6] = '{1, SB'(27),          16'd0,   16'h0000, 2'd2, 40,  18, 4};
    vt[7] = '{1, SB'(6),           16'd8,   16'h0000, 2'd0, 36,  18, 2};

    for (int i = 0; i < 2; i++) begin cmd_valid[i] = 1'b0; cmd_seed[i] = '0; end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_cmd_ready", cmd_ready[i], 1);
      chk("reset_rsp_valid", rsp_valid[i], 0);
      chk("reset_rsp_fields", {rsp_orbit_len[i], rsp_path_h16[i], rsp_error[i]}, 0);
      chk("reset_dev_rst_n", dev_rst_n[i], 0);
      chk("reset_dev_pins", {dev_ui_in[i], dev_uio_in[i]}, 0);
    end
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_cmd(vt[v].inst, vt[v].seed, got, lat, orb, pth, err, dwr, drst, dact, dae);
      chk($sformatf("v%0d_rsp_seen", v), got, 1);
      chk($sformatf("v%0d_error", v), err, vt[v].err);
      chk($sformatf("v%0d_orbit", v), orb, vt[v].orbit);
      chk($sformatf("v%0d_path", v), pth, vt[v].path);
      chk($sformatf("v%0d_latency", v), lat, vt[v].lat);
      chk($sformatf("v%0d_write_strobes", v), dwr, vt[v].wr);
      chk($sformatf("v%0d_write_addr_order", v), dae, 0);
      chk($sformatf("v%0d_dev_rst_low_cycles", v), drst, vt[v].rl);
      if (vt[v].err == 2'd1) chk($sformatf("v%0d_no_dev_activity", v), dact, 0);
    end

    // Reset in the middle of a command: back to IDLE and no response.
    @(negedge clk);
    cmd_valid[0] = 1'b1; cmd_seed[0] = SB'(27);
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("midreset_cmd_ready", cmd_ready[0], 1);
    chk("midreset_dev_rst_n", dev_rst_n[0], 0);
    chk("midreset_dev_uio_in", dev_uio_in[0], 0);
    hits = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rsp_valid[0]) hits++;
    end
    chk("midreset_no_rsp", hits, 0);
    run_cmd(0, SB'(6), got, lat, orb, pth, err, dwr, drst, dact, dae);
    chk("after_midreset_seen", got, 1);
    chk("after_midreset_orbit", orb, 8);
    chk("after_midreset_latency", lat, 36);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
